wb_trace: RTL and testbench

WB_TRACE -- requirements
Module: wb_trace

---
 rtl/wb_trace_pkg.sv | 14 +
 rtl/trace_ram.sv | 34 +++
 rtl/wb_trace.sv | 173 +++++++++++++++++
 tb/tb_wb_trace.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared state encodings and stamp width for the WB trace buffer
package wb_trace_pkg;

    // Width of the free-running cycle stamp stored with every entry.
    localparam int STAMP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace entry storage, one write port and an asynchronous read port
//
// Ports:
//   clk    rising-edge write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 88,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are never reset; validity is tracked by the controller's count.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace.sv
// rtl/wb_trace.sv - writeback-stage instruction trace buffer with PC trigger and post-trigger capture
//
// Ports:
//   iw_clk, iw_rst_n                clock, asynchronous active-low reset
//   iw_wb_valid/pc/instr/result     retiring instruction from WB
//   iw_arm, iw_clear                start capture / abort and empty
//   iw_trig_en, iw_trig_pc          PC trigger
//   iw_post                         entries captured after the trigger (sampled at trigger)
//   iw_rd_ready                     reader accepts the oldest entry
//   ow_rd_valid/pc/instr/result/stamp  oldest entry (valid only in FROZEN)
//   ow_count, ow_state, ow_overflow    occupancy, FSM state, sticky overwrite flag
module wb_trace
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 24,
    parameter int INSTR_W = 24,
    parameter int DATA_W  = 24
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst_n,
    input  logic                     iw_wb_valid,
    input  logic [ADDR_W-1:0]        iw_wb_pc,
    input  logic [INSTR_W-1:0]       iw_wb_instr,
    input  logic [DATA_W-1:0]        iw_wb_result,
    input  logic                     iw_arm,
    input  logic                     iw_clear,
    input  logic                     iw_trig_en,
    input  logic [ADDR_W-1:0]        iw_trig_pc,
    input  logic [$clog2(DEPTH):0]   iw_post,
    input  logic                     iw_rd_ready,
    output logic                     ow_rd_valid,
    output logic [ADDR_W-1:0]        ow_rd_pc,
    output logic [INSTR_W-1:0]       ow_rd_instr,
    output logic [DATA_W-1:0]        ow_rd_result,
    output logic [STAMP_W-1:0]       ow_rd_stamp,
    output logic [$clog2(DEPTH):0]   ow_count,
    output logic [1:0]               ow_state,
    output logic                     ow_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INSTR_W + DATA_W + STAMP_W;

    trace_state_t       state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   post_cnt;
    logic [STAMP_W-1:0] stamp;
    logic               overflow;

    logic               capturing;
    logic               wr_en;
    logic               trig_hit;
    logic               full;
    logic               rd_valid;
    logic               pop;
    logic [ENT_W-1:0]   wr_data;
    logic [ENT_W-1:0]   rd_data;

    assign capturing = (state == ST_ARMED) || (state == ST_POST);
    // Clear aborts the cycle's write as well as the capture.
    assign wr_en     = capturing && iw_wb_valid && !iw_clear;
    assign trig_hit  = (state == ST_ARMED) && iw_wb_valid && iw_trig_en &&
                       (iw_wb_pc == iw_trig_pc);
    assign full      = (count == CNT_W'(DEPTH));
    assign rd_valid  = (state == ST_FROZEN) && (count != '0);
    assign pop       = rd_valid && iw_rd_ready;
    assign wr_data   = {iw_wb_pc, iw_wb_instr, iw_wb_result, stamp};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (iw_clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Free-running stamp; only reset restarts it, clear does not.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            overflow <= 1'b0;
        end else if (iw_clear) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            // Writes happen only in ARMED/POST and pops only in FROZEN, so the
            // two pointer updates below never collide.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full) begin
                    // Ring is full: drop the oldest entry, occupancy stays at DEPTH.
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (iw_arm) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        if (iw_post == '0) begin
                            state <= ST_FROZEN;
                        end else begin
                            state    <= ST_POST;
                            post_cnt <= iw_post;
                        end
                    end
                end
                ST_POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt - CNT_W'(1);
                        if (post_cnt == CNT_W'(1)) begin
                            state <= ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ow_state    = state;
    assign ow_count    = count;
    assign ow_overflow = overflow;
    assign ow_rd_valid = rd_valid;

    // Entry fields are forced to zero when nothing is readable so stale RAM
    // contents never appear on the read port (including right after reset).
    assign ow_rd_pc     = rd_valid ? rd_data[ENT_W-1 -: ADDR_W] : '0;
    assign ow_rd_instr  = rd_valid ? rd_data[DATA_W+STAMP_W +: INSTR_W] : '0;
    assign ow_rd_result = rd_valid ? rd_data[STAMP_W +: DATA_W] : '0;
    assign ow_rd_stamp  = rd_valid ? rd_data[STAMP_W-1:0] : '0;

endmodule

// File: tb/tb_wb_trace.sv
// tb/tb_wb_trace.sv - self-checking bench for wb_trace against a queue-based reference model
module tb_wb_trace;

    localparam int DEPTH    = 16;
    localparam int S_IDLE   = 0;
    localparam int S_ARMED  = 1;
    localparam int S_POST   = 2;
    localparam int S_FROZEN = 3;

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] result;
        logic [15:0] stamp;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [23:0] wb_pc;
    logic [23:0] wb_instr;
    logic [23:0] wb_result;
    logic        arm;
    logic        clear;
    logic        trig_en;
    logic [23:0] trig_pc;
    logic [4:0]  post;
    logic        rd_ready;
    logic        rd_valid;
    logic [23:0] rd_pc;
    logic [23:0] rd_instr;
    logic [23:0] rd_result;
    logic [15:0] rd_stamp;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        overflow;

    always #5 clk = ~clk;

    wb_trace #(
        .DEPTH   (DEPTH),
        .ADDR_W  (24),
        .INSTR_W (24),
        .DATA_W  (24)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_wb_valid  (wb_valid),
        .iw_wb_pc     (wb_pc),
        .iw_wb_instr  (wb_instr),
        .iw_wb_result (wb_result),
        .iw_arm       (arm),
        .iw_clear     (clear),
        .iw_trig_en   (trig_en),
        .iw_trig_pc   (trig_pc),
        .iw_post      (post),
        .iw_rd_ready  (rd_ready),
        .ow_rd_valid  (rd_valid),
        .ow_rd_pc     (rd_pc),
        .ow_rd_instr  (rd_instr),
        .ow_rd_result (rd_result),
        .ow_rd_stamp  (rd_stamp),
        .ow_count     (count),
        .ow_state     (state),
        .ow_overflow  (overflow)
    );

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    int          m_state;
    logic        m_ovf;
    int          m_post;
    logic [15:0] m_stamp;
    logic [23:0] held_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = S_IDLE;
        m_ovf   = 1'b0;
        m_post  = 0;
        m_stamp = 16'd0;
    endtask

    // Applies one clock edge of the trace rules to the queue model.
    task automatic model_update();
        ent_t e;
        if (clear) begin
            m_state = S_IDLE;
            q.delete();
            m_ovf  = 1'b0;
            m_post = 0;
        end else begin
            case (m_state)
                S_IDLE: if (arm) m_state = S_ARMED;
                S_ARMED, S_POST: begin
                    if (wb_valid) begin
                        e.pc     = wb_pc;
                        e.instr  = wb_instr;
                        e.result = wb_result;
                        e.stamp  = m_stamp;
                        q.push_back(e);
                        if (q.size() > DEPTH) begin
                            q.delete(0);
                            m_ovf = 1'b1;
                        end
                        if (m_state == S_ARMED) begin
                            if (trig_en && wb_pc == trig_pc) begin
                                if (post == 0) m_state = S_FROZEN;
                                else begin
                                    m_state = S_POST;
                                    m_post  = int'(post);
                                end
                            end
                        end else begin
                            m_post--;
                            if (m_post == 0) m_state = S_FROZEN;
                        end
                    end
                end
                default: begin
                    if (q.size() == 0) m_state = S_IDLE;
                    else if (rd_ready) q.delete(0);
                end
            endcase
        end
        m_stamp = m_stamp + 16'd1;
    endtask

    task automatic compare_all();
        logic exp_valid;
        exp_valid = (m_state == S_FROZEN) && (q.size() > 0);
        check("state", 32'(state), 32'(m_state));
        check("count", 32'(count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("rd_pc", 32'(rd_pc), 32'(q[0].pc));
            check("rd_instr", 32'(rd_instr), 32'(q[0].instr));
            check("rd_result", 32'(rd_result), 32'(q[0].result));
            check("rd_stamp", 32'(rd_stamp), 32'(q[0].stamp));
        end
    endtask

    // Inputs are set between edges; outputs are compared 1 time unit after the edge.
    task automatic drive(input logic v, input logic [23:0] pc, input logic a, input logic c,
                         input logic te, input logic [23:0] tp, input logic [4:0] po,
                         input logic rr);
        wb_valid  = v;
        wb_pc     = pc;
        wb_instr  = 24'($urandom);
        wb_result = 24'($urandom);
        arm       = a;
        clear     = c;
        trig_en   = te;
        trig_pc   = tp;
        post      = po;
        rd_ready  = rr;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle();
        drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0);
    endtask

    task automatic clear_arm();
        drive(1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0, 5'd0, 1'b0);
        drive(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_result = '0;
        arm = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; post = '0; rd_ready = 1'b0;
        model_reset();
        #20;
        compare_all();
        check("reset_rd_pc", 32'(rd_pc), 32'd0);
        #2 rst_n = 1'b1;

        // Untriggered capture wraps the ring and sets overflow.
        clear_arm();
        for (int p = 0; p < 20; p++) drive(1'b1, 24'(p), 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0);
        check("req023_count", 32'(count), 32'd16);
        check("req023_overflow", 32'(overflow), 32'd1);
        check("req023_state", 32'(state), 32'(S_ARMED));

        // Trigger at 0x10 with three post entries; retires past the freeze are ignored.
        clear_arm();
        for (int p = 4; p <= 32; p++) begin
            drive(1'b1, 24'(p), 1'b0, 1'b0, 1'b1, 24'h10, 5'd3, 1'b0);
            if (p == 19) check("req024_frozen", 32'(state), 32'(S_FROZEN));
        end
        check("req024_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("req024_order", 32'(rd_pc), 32'(4 + i));
            drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b1);
        end
        idle();
        check("req024_idle", 32'(state), 32'(S_IDLE));

        // Post of zero freezes on the triggering retire.
        clear_arm();
        drive(1'b1, 24'h55, 1'b0, 1'b0, 1'b1, 24'h55, 5'd0, 1'b0);
        check("req025_state", 32'(state), 32'(S_FROZEN));
        check("req025_count", 32'(count), 32'd1);
        check("req025_valid", 32'(rd_valid), 32'd1);

        // Ready 1,0,1: two pops, data held while ready is low.
        clear_arm();
        for (int p = 1; p <= 3; p++) drive(1'b1, 24'(p), 1'b0, 1'b0, 1'b1, 24'd3, 5'd0, 1'b0);
        drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b1);
        held_pc = rd_pc;
        check("req026_next", 32'(held_pc), 32'd2);
        drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0);
        check("req026_hold", 32'(rd_pc), 32'(held_pc));
        drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b1);
        check("req026_pops", 32'(count), 32'd1);
        drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b1);
        idle();
        check("req026_idle", 32'(state), 32'(S_IDLE));

        // Clear wins over arm during POST and drops overflow.
        clear_arm();
        for (int p = 0; p < 17; p++) drive(1'b1, 24'(256 + p), 1'b0, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0);
        drive(1'b1, 24'h40, 1'b0, 1'b0, 1'b1, 24'h40, 5'd5, 1'b0);
        check("req027_post", 32'(state), 32'(S_POST));
        drive(1'b1, 24'h41, 1'b1, 1'b1, 1'b1, 24'h41, 5'd0, 1'b0);
        check("req027_state", 32'(state), 32'(S_IDLE));
        check("req027_count", 32'(count), 32'd0);
        check("req027_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset in POST clears outputs with no clock edge.
        clear_arm();
        for (int p = 0; p < 5; p++) drive(1'b1, 24'(p), 1'b0, 1'b0, 1'b1, 24'd4, 5'd8, 1'b0);
        check("req028_post", 32'(state), 32'(S_POST));
        #2 rst_n = 1'b0;
        #1;
        check("req028_state", 32'(state), 32'd0);
        check("req028_count", 32'(count), 32'd0);
        check("req028_overflow", 32'(overflow), 32'd0);
        check("req028_valid", 32'(rd_valid), 32'd0);
        check("req028_pc", 32'(rd_pc), 32'd0);
        check("req028_instr", 32'(rd_instr), 32'd0);
        check("req028_result", 32'(rd_result), 32'd0);
        check("req028_stamp", 32'(rd_stamp), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 10) < 7, 24'($urandom % 32), ($urandom % 8) == 0,
                  ($urandom % 200) == 0, ($urandom % 4) != 0, 24'($urandom % 32),
                  5'($urandom % 12), 1'($urandom % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
